// File: rtl/shift_decode_scheduler_if.sv
// Requester/response and decode-datapath signals of shift_decode_scheduler.
// slave = scheduler side; master = requesters, response consumer and datapath.
interface shift_decode_scheduler_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [64*NREQ-1:0] req_data;
    logic [64*NREQ-1:0] req_key;
    logic [NREQ-1:0]    req_ready;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [2:0]         rsp_id;
    logic [63:0]        rsp_data;
    logic               rsp_err;
    logic               busy;

    logic               dp_set;
    logic [63:0]        dp_data;
    logic [63:0]        dp_key;
    logic               dp_status;
    logic [63:0]        dp_result;

    modport slave (
        input  req_valid, req_data, req_key, rsp_ready, dp_status, dp_result,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy,
        output dp_set, dp_data, dp_key
    );

    modport master (
        output req_valid, req_data, req_key, rsp_ready, dp_status, dp_result,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy,
        input  dp_set, dp_data, dp_key
    );
endinterface

// File: rtl/shift_decode_scheduler.sv
// Round-robin scheduler sharing one inverse-shift decode datapath among NREQ requesters.
// Accept->rsp_valid 3 cycles (TIMEOUT+2 on timeout); rsp_valid holds until rsp_ready, no accepts meanwhile.
module shift_decode_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    set_n,
    shift_decode_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    state_t      state_q;
    logic [2:0]  last_grant_q;
    logic [2:0]  rsp_id_q;
    logic [63:0] rsp_data_q;
    logic        rsp_err_q;
    logic        dp_set_q;
    logic [63:0] dp_data_q;
    logic [63:0] dp_key_q;
    logic [7:0]  tmo_cnt_q;

    logic [7:0]      vld_pad;
    logic [3:0]      idx;
    logic [2:0]      grant_d;
    logic            grant_vld;
    logic [NREQ-1:0] req_ready_d;
    logic [63:0]     data_d;
    logic [63:0]     key_d;

    always_comb begin
        vld_pad            = '0;
        vld_pad[NREQ-1:0]  = bus.req_valid;
        idx                = '0;
        grant_d            = '0;
        grant_vld          = 1'b0;
        // Scan from farthest to nearest so the first valid slot after last_grant_q wins.
        for (int i = NREQ; i >= 1; i--) begin
            idx = 4'(last_grant_q) + 4'(i);
            if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
            if (vld_pad[idx[2:0]]) begin
                grant_d   = idx[2:0];
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        data_d      = '0;
        key_d       = '0;
        req_ready_d = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_d == 3'(k)) begin
                data_d         = bus.req_data[64*k +: 64];
                key_d          = bus.req_key[64*k +: 64];
                req_ready_d[k] = grant_vld && (state_q == IDLE);
            end
        end
    end

    always_ff @(posedge clk or negedge set_n) begin
        if (!set_n) begin
            state_q      <= IDLE;
            last_grant_q <= 3'(NREQ - 1);
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            dp_set_q     <= 1'b1;
            dp_data_q    <= '0;
            dp_key_q     <= '0;
            tmo_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        dp_data_q <= data_d;
                        dp_key_q  <= key_d;
                        rsp_id_q  <= grant_d;
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    state_q   <= RUN;
                    dp_set_q  <= 1'b0;
                    tmo_cnt_q <= '0;
                end
                RUN: begin
                    // The counter lags the first RUN cycle, in which the datapath cannot answer yet.
                    if (bus.dp_status) begin
                        rsp_data_q <= bus.dp_result;
                        rsp_err_q  <= 1'b0;
                        dp_set_q   <= 1'b1;
                        state_q    <= RESP;
                    end else if (tmo_cnt_q == 8'(TIMEOUT)) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                        dp_set_q   <= 1'b1;
                        state_q    <= RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        last_grant_q <= rsp_id_q;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_d;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.dp_set    = dp_set_q;
    assign bus.dp_data   = dp_data_q;
    assign bus.dp_key    = dp_key_q;
endmodule

// File: tb/tb_shift_decode_scheduler.sv
// Directed bench for shift_decode_scheduler with a behavioural inverse-shift datapath of programmable delay.
module tb_shift_decode_scheduler;
    localparam int NREQ = 4;

    logic clk   = 1'b0;
    logic set_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   dp_delay = 0;
    int   dp_cnt   = 0;

    shift_decode_scheduler_if #(.NREQ(NREQ)) bus ();

    shift_decode_scheduler #(.NREQ(NREQ), .TIMEOUT(15)) dut (
        .clk   (clk),
        .set_n (set_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Output byte i (MSB first) is input byte (key - i) mod 8.
    function automatic logic [63:0] dec(input logic [63:0] d, input logic [63:0] k);
        logic [63:0] r;
        int s;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            s = (int'(k[2:0]) - i) & 7;
            r[63-8*i -: 8] = d[63-8*s -: 8];
        end
        return r;
    endfunction

    // Datapath: synchronous clear on dp_set, answers dp_delay cycles after clear is released.
    always @(posedge clk) begin
        if (bus.dp_set) begin
            bus.dp_status <= 1'b0;
            bus.dp_result <= '0;
            dp_cnt        <= 0;
        end else if (dp_cnt == dp_delay) begin
            bus.dp_status <= 1'b1;
            bus.dp_result <= dec(bus.dp_data, bus.dp_key);
        end else begin
            dp_cnt <= dp_cnt + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          slot;
        logic [63:0] data;
        logic [63:0] key;
        int          delay;
        logic [3:0]  exp_ready;
        logic [2:0]  exp_id;
        logic [63:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];
    int   rr_exp[5];

    initial begin
        int lat;
        int acc;
        int n;

        vecs[0] = '{0, 64'h0102030405060708, 64'd0, 0,    4'b0001, 3'd0, 64'h0108070605040302, 1'b0, 3};
        vecs[1] = '{2, 64'h0102030405060708, 64'd1, 0,    4'b0100, 3'd2, 64'h0201080706050403, 1'b0, 3};
        vecs[2] = '{1, 64'h8899aabbccddeeff, 64'd0, 0,    4'b0010, 3'd1, 64'h88ffeeddccbbaa99, 1'b0, 3};
        vecs[3] = '{3, 64'h1122334455667788, 64'd2, 0,    4'b1000, 3'd3, 64'h3322118877665544, 1'b0, 3};
        vecs[4] = '{0, 64'h0102030405060708, 64'd0, 1000, 4'b0001, 3'd0, 64'h0,                1'b1, 17};
        vecs[5] = '{1, 64'h0102030405060708, 64'd1, 14,   4'b0010, 3'd1, 64'h0201080706050403, 1'b0, 17};
        vecs[6] = '{2, 64'h0102030405060708, 64'd0, 15,   4'b0100, 3'd2, 64'h0,                1'b1, 17};
        vecs[7] = '{3, 64'h0102030405060708, 64'd0, 0,    4'b1000, 3'd3, 64'h0108070605040302, 1'b0, 3};
        rr_exp  = '{0, 1, 2, 3, 0};

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_key   = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_dp_set",    bus.dp_set,    1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_busy",      bus.busy,      0);
        chk("rst_dp_data",   bus.dp_data,   0);
        chk("rst_dp_key",    bus.dp_key,    0);
        chk("rst_rsp_id",    bus.rsp_id,    0);
        chk("rst_rsp_data",  bus.rsp_data,  0);
        chk("rst_rsp_err",   bus.rsp_err,   0);
        set_n = 1'b1;
        #1;
        chk("idle_no_req_ready", bus.req_ready, 0);
        bus.rsp_ready = 1'b1;
        tick;

        // Single-slot jobs: decode results, latency and timeout boundaries
        for (int v = 0; v < 8; v++) begin
            dp_delay = vecs[v].delay;
            bus.req_valid = '0;
            bus.req_valid[vecs[v].slot] = 1'b1;
            bus.req_data[64*vecs[v].slot +: 64] = vecs[v].data;
            bus.req_key[64*vecs[v].slot +: 64]  = vecs[v].key;
            #1;
            chk("req_ready", bus.req_ready, vecs[v].exp_ready);
            tick;
            bus.req_valid = '0;
            chk("dp_data_latched", bus.dp_data, vecs[v].data);
            chk("dp_key_latched",  bus.dp_key,  vecs[v].key);
            lat = 0;
            while (!bus.rsp_valid && lat < 40) begin
                tick;
                lat++;
            end
            chk("latency",  64'(lat),     64'(vecs[v].exp_lat));
            chk("rsp_id",   bus.rsp_id,   vecs[v].exp_id);
            chk("rsp_data", bus.rsp_data, vecs[v].exp_data);
            chk("rsp_err",  bus.rsp_err,  vecs[v].exp_err);
            tick;
            chk("idle_after_rsp", bus.busy, 0);
        end
        dp_delay = 0;

        // Round robin with all slots requesting; last served slot was 3
        bus.req_valid = 4'hF;
        acc = 0;
        #1;
        for (int c = 0; c <= 20; c++) begin
            if (bus.req_ready != '0) begin
                if (acc < 5) begin
                    chk("rr_grant", bus.req_ready, 64'(4'b0001 << rr_exp[acc]));
                    chk("rr_cycle", 64'(c), 64'(acc * 5));
                    acc++;
                end else begin
                    chk("rr_extra_grant", bus.req_ready, 0);
                end
            end
            tick;
        end
        bus.req_valid = '0;
        chk("rr_grant_count", 64'(acc), 64'd5);
        n = 0;
        while (bus.busy && n < 40) begin
            tick;
            n++;
        end
        chk("rr_drain", bus.busy, 0);

        // Response backpressure; slot 2 waits behind slot 1
        bus.rsp_ready = 1'b0;
        bus.req_data[64*1 +: 64] = 64'h0102030405060708;
        bus.req_key[64*1 +: 64]  = 64'd0;
        bus.req_valid = 4'b0110;
        #1;
        chk("bp_grant", bus.req_ready, 4'b0010);
        tick;
        bus.req_valid = 4'b0100;
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            tick;
            n++;
        end
        for (int c = 0; c < 10; c++) begin
            chk("bp_rsp_valid", bus.rsp_valid, 1);
            chk("bp_rsp_id",    bus.rsp_id,    1);
            chk("bp_rsp_data",  bus.rsp_data,  64'h0108070605040302);
            chk("bp_req_ready", bus.req_ready, 0);
            chk("bp_dp_data",   bus.dp_data,   64'h0102030405060708);
            tick;
        end
        bus.rsp_ready = 1'b1;
        tick;
        chk("bp_idle", bus.busy, 0);
        chk("bp_next_grant", bus.req_ready, 4'b0100);
        bus.req_valid = '0;

        // Reset during RUN, then priority returns to slot 0
        bus.req_data[64*2 +: 64] = 64'h1122334455667788;
        bus.req_valid = 4'b0100;
        tick;
        bus.req_valid = '0;
        tick;
        chk("run_busy", bus.busy, 1);
        #2;
        set_n = 1'b0;
        #1;
        chk("mid_rst_dp_set",    bus.dp_set,    1);
        chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
        chk("mid_rst_busy",      bus.busy,      0);
        chk("mid_rst_dp_data",   bus.dp_data,   0);
        bus.req_data[64*0 +: 64] = 64'h0102030405060708;
        bus.req_key[64*0 +: 64]  = 64'd1;
        bus.req_valid = 4'b0011;
        #2;
        set_n = 1'b1;
        #1;
        chk("post_rst_grant", bus.req_ready, 4'b0001);
        tick;
        bus.req_valid = 4'b0010;
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            tick;
            n++;
        end
        chk("post_rst_rsp_id",   bus.rsp_id,   0);
        chk("post_rst_rsp_data", bus.rsp_data, 64'h0201080706050403);
        bus.req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
